// File: rtl/vr_256_to_reg.sv
// Single-entry buffer from a 256-bit valid/ready hash stream to a 32-bit register read interface.
// Optional feature macro: VR_TO_REG_IRQ_EN (adds irq output and IRQ_MASK control bit).
module vr_256_to_reg #(
  parameter int ADDRWIDTH = 12,
  parameter bit AUTO_POP  = 1'b1
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [255:0]         data_in,
  input  logic [5:0]           data_in_id,
  input  logic                 data_in_last,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [3:0]           byte_strobe,
  input  logic [31:0]          wdata,
`ifdef VR_TO_REG_IRQ_EN
  output logic                 irq,
`endif
  output logic [31:0]          rdata
);

  localparam logic [3:0] REG_WORD7  = 4'd7;
  localparam logic [3:0] REG_STATUS = 4'd8;
  localparam logic [3:0] REG_CTRL   = 4'd9;

  logic         full_q, full_d;
  logic [255:0] data_q, data_d;
  logic [5:0]   id_q, id_d;
  logic         last_q, last_d;
  logic [15:0]  count_q, count_d;
  logic         underflow_q, underflow_d;
  logic         ready_q, ready_d;
  logic         mask_q, mask_d;

  logic         addr_hit;
  logic [3:0]   reg_idx;
  logic         ctrl_wr;
  logic         pop;
  logic         capture;
  logic [31:0]  status;

  always_comb begin
    addr_hit = (addr[ADDRWIDTH-1:6] == '0);
    reg_idx  = addr[5:2];
    ctrl_wr  = write_en & addr_hit & (reg_idx == REG_CTRL) & byte_strobe[0];
    capture  = data_in_valid & data_in_ready;
    pop      = (ctrl_wr & wdata[0])
             | (AUTO_POP & read_en & addr_hit & (reg_idx == REG_WORD7) & full_q);
  end

  always_comb begin
    full_d      = full_q;
    data_d      = data_q;
    id_d        = id_q;
    last_d      = last_q;
    count_d     = count_q;
    underflow_d = underflow_q;
    mask_d      = mask_q;

    if (capture) begin
      full_d = 1'b1;
      data_d = data_in;
      id_d   = data_in_id;
      last_d = data_in_last;
    end

    if (ctrl_wr & wdata[1]) count_d = capture ? 16'd1 : 16'd0;
    else if (capture)       count_d = count_q + 16'd1;

    // Clear first so an underflowing pop in the same write wins over CLR_ERR.
    if (ctrl_wr & wdata[2]) underflow_d = 1'b0;
    if (pop) begin
      if (full_q) full_d = 1'b0;
      else        underflow_d = 1'b1;
    end

`ifdef VR_TO_REG_IRQ_EN
    if (ctrl_wr) mask_d = wdata[3];
`else
    mask_d = 1'b0;
`endif

    ready_d = ~full_d;
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      full_q      <= 1'b0;
      data_q      <= '0;
      id_q        <= '0;
      last_q      <= 1'b0;
      count_q     <= '0;
      underflow_q <= 1'b0;
      mask_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      full_q      <= full_d;
      data_q      <= data_d;
      id_q        <= id_d;
      last_q      <= last_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
      mask_q      <= mask_d;
      ready_q     <= ready_d;
    end
  end

  // ready_q already reflects the empty post-reset buffer; hresetn only masks it while reset is held.
  assign data_in_ready = ready_q & hresetn;

`ifdef VR_TO_REG_IRQ_EN
  logic irq_q, irq_d;

  always_comb irq_d = full_d & ~mask_d;

  always_ff @(posedge hclk) begin
    if (!hresetn) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`endif

  always_comb begin
    status = {count_q, 2'b00, id_q, 4'b0000, mask_q, underflow_q, last_q, full_q};
    rdata  = 32'd0;
    if (read_en && addr_hit) begin
      if (reg_idx <= REG_WORD7)        rdata = data_q[{reg_idx[2:0], 5'd0} +: 32];
      else if (reg_idx == REG_STATUS)  rdata = status;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{addr[1:0], byte_strobe[3:1], wdata[31:4]};

endmodule

// File: doc/vr_256_to_reg.md
Name: vr_256_to_reg

Overview:
- Reader-side counterpart to the register-to-512-bit input packer on the SHA-256 compression AHB wrapper.
- Accepts one 256-bit hash result (plus id and last flag) from the engine's valid/ready output stream.
- Holds the result in a single-entry buffer and exposes it as eight 32-bit words, a status register and a control register on the simple register interface produced by the AHB slave interface.
- Software reads the digest and releases the buffer. Releasing re-opens the stream to the next result.

Parameters:
- ADDRWIDTH, 12, width of the register interface address.
- AUTO_POP, 1, when 1 a read of data word 7 also releases the buffer; when 0 only a control-register write releases it.

Ports:
- hclk  input  1  clock
- hresetn  input  1  reset, synchronous, active-low
- data_in  input  256  hash result; word n = data_in[32n+31:32n]
- data_in_id  input  6  block id
- data_in_last  input  1  last-block flag
- data_in_valid  input  1  stream valid
- data_in_ready  output  1  stream ready
- addr  input  ADDRWIDTH  register byte address
- read_en  input  1  register read strobe
- write_en  input  1  register write strobe
- byte_strobe  input  4  write byte lanes
- wdata  input  32  write data
- rdata  output  32  read data

Behaviour:
- Clocking and reset: one clock, hclk. Reset is synchronous and active-low on hresetn, sampled on the rising edge of hclk.
- Reset values: full=0, data buffer=0, id=0, last=0, count=0, underflow=0, data_in_ready=0 during reset and 1 from the first cycle after reset.
- Stream handshake:
  - data_in_ready = ~full, driven from a register, no combinational path from valid.
  - Capture on data_in_valid & data_in_ready: the buffer, id and last are loaded, full is set next edge, and count increments.
  - count is 16 bits and wraps 0xFFFF -> 0x0000.
- Address map: decode is addr[5:2], and only when addr[ADDRWIDTH-1:6]==0 and addr[1:0] are ignored.
  - 0x00-0x1C: data words 0-7, read-only.
  - 0x20 STATUS, read-only: bit0 full, bit1 last, bit2 underflow, bits13:8 id, bits31:16 count, other bits 0.
  - 0x24 CONTROL: write-only, reads 0. Bit0 POP, bit1 CLR_COUNT, bit2 CLR_ERR; all act only when byte_strobe[0]=1.
  - Any other address reads 0, and writes to it are ignored.
- rdata is a combinational decode of addr and the current state, valid in the read_en cycle. rdata=0 when read_en=0.
- Data words return the last captured contents even when full=0; they are not cleared on pop.
- Pop sources, either one releases the buffer:
  - a CONTROL write with POP;
  - when AUTO_POP=1, read_en at 0x1C while full=1.
- Pop effects:
  - Pop while full=1: full clears next edge and data_in_ready rises that same edge.
  - The earliest next capture is the cycle after the pop. Throughput is therefore at most one result per two cycles.
  - Pop while full=0 has no state change except underflow <= 1, which is sticky until CLR_ERR.
- Simultaneous events:
  - Capture and pop cannot coincide, because ready=0 while full.
  - CLR_COUNT in the same cycle as a capture: count <= 1.
  - CLR_ERR together with an underflowing POP: underflow stays 1 (set wins).
  - read_en and write_en are never both asserted by the interface; if they are, the write is performed and rdata is still the decode.
- Reset mid-operation: all state returns to reset values and any held result is discarded. An upstream valid held through reset is captured on the first cycle after reset.

Optional Feature:
- Macro name: VR_TO_REG_IRQ_EN.
- When defined: adds output irq (1 bit), registered, reset 0.
  - irq = 1 from the cycle after a capture until the cycle after the pop; it equals full delayed by zero cycles, driven from the same flop.
  - CONTROL bit3 IRQ_MASK, reset 0, gates irq; it is read back as STATUS bit3.
- When not defined: there is no irq port, STATUS bit3 reads 0 and CONTROL bit3 is ignored.

Test Plan:
- Reset then idle -> data_in_ready=1, STATUS read returns 0x00000000, and data words 0-7 read 0.
- Drive data_in=256'h0123...CDEF pattern (word n = 32'h1111_1111*n), id=6'h2A, last=1, valid one cycle -> data_in_ready=0 next cycle, STATUS=0x00012A03, and word 3 reads 0x33333333.
- Hold valid with a second result while full -> no capture until POP. Write CONTROL=0x1 -> ready=1 next cycle, the capture follows, and count reads 2.
- AUTO_POP=1: read 0x1C while full -> full=0 next cycle. With AUTO_POP=0, the same read leaves full=1.
- POP while empty -> STATUS bit2=1. Write CONTROL=0x4 -> bit2=0. Write with byte_strobe=4'b0010 and wdata=0x1 -> ignored.
- Force count to 0xFFFF via 65535 captures (or a back-door load), then capture one more -> count=0x0000. CLR_COUNT in the same cycle as a capture -> count=1.
